// File: rtl/alu_issue_unit_pkg.sv
// Shared types and constants for the ALU issue unit.
package alu_issue_unit_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned REG_AW = $clog2(NREGS);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    OpAnd = 3'b000,
    OpXor = 3'b001,
    OpShl = 3'b010,
    OpShr = 3'b011,
    OpAdd = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } issue_state_e;

  // 9-bit instruction word: op in the top bits, rs is ALU R1, rd is ALU R2 and destination.
  typedef struct packed {
    logic [2:0] op;
    reg_idx_t   rs;
    reg_idx_t   rd;
  } instr_t;

  // Encodings above add are reserved and reported as illegal.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction handshake and external register-load bus of the issue unit.
interface alu_issue_unit_if;
  import alu_issue_unit_pkg::*;

  logic     instr_valid;
  logic     instr_ready;
  instr_t   instr;
  logic     load_en;
  reg_idx_t load_addr;
  data_t    load_data;

  // Front end side.
  modport master (
    output instr_valid,
    input  instr_ready,
    output instr,
    output load_en,
    output load_addr,
    output load_data
  );

  // Issue unit side.
  modport slave (
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  load_en,
    input  load_addr,
    input  load_data
  );

endinterface

// File: rtl/alu_issue_unit_reg_file_8x8.sv
// 8x8 register file: one synchronous write port, three asynchronous read ports.
module reg_file_8x8
  import alu_issue_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we,
  input  reg_idx_t waddr,
  input  data_t    wdata,
  input  reg_idx_t rs_addr,
  input  reg_idx_t rd_addr,
  input  reg_idx_t dbg_addr,
  output data_t    rs_data,
  output data_t    rd_data,
  output data_t    dbg_data
);

  data_t regs_q [NREGS];

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rs_data  = regs_q[rs_addr];
  assign rd_data  = regs_q[rd_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue side of the 8-bit ALU: accepts an instruction, drives the ALU for one cycle,
// captures result and flags, then writes back. Fixed IDLE -> EXEC -> WB occupancy.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_unit_if.slave     bus,
  output logic [2:0]          alu_op,
  output data_t               alu_r1,
  output data_t               alu_r2,
  input  data_t               alu_out,
  input  logic [1:0]          alu_overflow,
  input  logic                alu_zf,
  output logic                done,
  output logic                illegal,
  output logic [1:0]          flag_ovf,
  output logic                flag_z,
  input  reg_idx_t            dbg_addr,
  output data_t               dbg_data
);

  issue_state_e state_q;
  instr_t       instr_q;
  logic [2:0]   alu_op_q;
  data_t        res_q;
  logic [1:0]   ovf_q;
  logic         z_q;
  logic         done_q;
  logic         illegal_q;
  logic         ready_q;
  logic [1:0]   flag_ovf_q;
  logic         flag_z_q;

  logic         rf_we;
  reg_idx_t     rf_waddr;
  data_t        rf_wdata;

  // Control FSM with registered handshake, ALU opcode, pulses and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      alu_op_q   <= 3'b000;
      res_q      <= '0;
      ovf_q      <= 2'b00;
      z_q        <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      ready_q    <= 1'b1;
      flag_ovf_q <= 2'b00;
      flag_z_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.instr_valid && ready_q) begin
            instr_q  <= bus.instr;
            alu_op_q <= bus.instr.op;
            ready_q  <= 1'b0;
            state_q  <= StExec;
          end
        end
        StExec: begin
          res_q    <= alu_out;
          ovf_q    <= alu_overflow;
          z_q      <= alu_zf;
          alu_op_q <= 3'b000;
          if (op_is_legal(instr_q.op)) begin
            done_q <= 1'b1;
          end else begin
            illegal_q <= 1'b1;
          end
          state_q <= StWb;
        end
        StWb: begin
          // Only add produces meaningful flags; every other op leaves them alone.
          if (instr_q.op == OpAdd) begin
            flag_ovf_q <= ovf_q;
            flag_z_q   <= z_q;
          end
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Single write port: writeback in WB, external load in IDLE; states never overlap.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.load_addr;
    rf_wdata = bus.load_data;
    if (state_q == StWb && done_q) begin
      rf_we    = 1'b1;
      rf_waddr = instr_q.rd;
      rf_wdata = res_q;
    end else if (state_q == StIdle && bus.load_en) begin
      rf_we = 1'b1;
    end
  end

  reg_file_8x8 u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rs_addr  (instr_q.rs),
    .rd_addr  (instr_q.rd),
    .dbg_addr (dbg_addr),
    .rs_data  (alu_r1),
    .rd_data  (alu_r2),
    .dbg_data (dbg_data)
  );

  assign bus.instr_ready = ready_q;
  assign alu_op          = alu_op_q;
  assign done            = done_q;
  assign illegal         = illegal_q;
  assign flag_ovf        = flag_ovf_q;
  assign flag_z          = flag_z_q;

endmodule
